// File: rtl/pio_in_pkg.sv
// Shared constants for the debounced input PIO: register word addresses
// and the debounce counter width helper.
package pio_in_pkg;

   localparam logic [2:0] ADDR_DATA = 3'd0;
   localparam logic [2:0] ADDR_RAW  = 3'd1;
   localparam logic [2:0] ADDR_MASK = 3'd2;
   localparam logic [2:0] ADDR_CAPT = 3'd3;
   localparam logic [2:0] ADDR_RISE = 3'd4;
   localparam logic [2:0] ADDR_FALL = 3'd5;

   // Bits needed to hold 0..cycles; never narrower than one bit.
   function automatic int cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/pio_debounced_in_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO.
interface pio_debounced_in_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/pio_debounce_cell.sv
// One input channel: 2-FF synchroniser followed by a hold-time debouncer.
// update is high in the cycle whose clock edge moves level to raw.
module pio_debounce_cell
   import pio_in_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic raw,
   output logic level,
   output logic update
);

   localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Next-state: count consecutive cycles the synchronised input disagrees
   // with the accepted level; accept it once the run is long enough.
   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      st_d    = st_q;
      cnt_d   = cnt_q;
      update  = 1'b0;
      if (sync2_q == st_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         st_d   = sync2_q;
         cnt_d  = '0;
         update = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // State registers; reset drops any debounce run without an update.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         st_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         st_q    <= st_d;
         cnt_q   <= cnt_d;
      end
   end

   assign raw   = sync2_q;
   assign level = st_q;

endmodule

// File: rtl/pio_debounced_in.sv
// Debounced edge-capture input PIO on an Avalon-MM slave port.
// Per-channel debounce cells feed a register file with W1C edge capture
// and a masked level interrupt.
module pio_debounced_in
   import pio_in_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   pio_debounced_in_if.slave  bus,
   input  logic [WIDTH-1:0]   in_port,
   output logic               irq
);

   logic [WIDTH-1:0] raw, level, upd;
   logic [WIDTH-1:0] rise_ev, fall_ev, clr;
   logic [WIDTH-1:0] wdata;
   logic             wr_en;
   logic             unused_wdata;

   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] capt_q, capt_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [31:0]      rdata_q, rdata_d;

   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_ch
         pio_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_cell (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (in_port[g]),
            .raw    (raw[g]),
            .level  (level[g]),
            .update (upd[g])
         );
      end
   endgenerate

   assign wr_en        = bus.chipselect & ~bus.write_n;
   assign wdata        = bus.writedata[WIDTH-1:0];
   assign unused_wdata = ^bus.writedata;

   // On an update the new level equals raw, so raw selects rise vs fall.
   assign rise_ev = upd &  raw & rise_q;
   assign fall_ev = upd & ~raw & fall_q;

   // Register file next-state; capture sets override same-cycle clears.
   always_comb begin
      mask_d = mask_q;
      rise_d = rise_q;
      fall_d = fall_q;
      clr    = '0;
      if (wr_en) begin
         case (bus.address)
            ADDR_MASK: mask_d = wdata;
            ADDR_CAPT: clr    = wdata;
            ADDR_RISE: rise_d = wdata;
            ADDR_FALL: fall_d = wdata;
            default:   ;
         endcase
      end
      capt_d = (capt_q & ~clr) | rise_ev | fall_ev;
   end

   // Read mux, registered every cycle regardless of chipselect.
   always_comb begin
      rdata_d = '0;
      case (bus.address)
         ADDR_DATA: rdata_d = 32'(level);
         ADDR_RAW:  rdata_d = 32'(raw);
         ADDR_MASK: rdata_d = 32'(mask_q);
         ADDR_CAPT: rdata_d = 32'(capt_q);
         ADDR_RISE: rdata_d = 32'(rise_q);
         ADDR_FALL: rdata_d = 32'(fall_q);
         default:   rdata_d = '0;
      endcase
   end

   // Register state; edge enables come up as any-edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mask_q  <= '0;
         capt_q  <= '0;
         rise_q  <= '1;
         fall_q  <= '1;
         rdata_q <= '0;
      end else begin
         mask_q  <= mask_d;
         capt_q  <= capt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.readdata = rdata_q;
   assign irq          = |(capt_q & mask_q);

endmodule

// File: doc/pio_debounced_in.md
# pio_debounced_in

Parametrised Avalon-MM input PIO for switch and button banks, the next generation of the team's 8-bit edge-capture input port. Each channel is synchronised, debounced by a per-channel counter, and edge-detected with per-bit rising/falling selection. Edge-capture bits are write-1-to-clear and drive a masked level interrupt. The block sits on the Nios II data bus, one instance per physical input bank.

## Interface
- WIDTH, 8: number of input channels, 1..32.
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised input must hold a new level before it is accepted, ≥1.
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock, reset is synchronous and active-low.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits [WIDTH-1:0] used.
- in_port  in  WIDTH  asynchronous raw inputs.
- readdata  out  32  registered read data, zero-extended above WIDTH.
- irq  out  1  level interrupt, high while any masked capture bit is set.

## Operation
- Register map, by word address:
  - 0 DATA (RO): debounced levels.
  - 1 RAW (RO): synchronised, undebounced levels.
  - 2 IRQ_MASK (RW).
  - 3 EDGE_CAPTURE (W1C).
  - 4 RISE_EN (RW).
  - 5 FALL_EN (RW).
  - 6 and 7 read 0; writes ignored.
- Writes to RO addresses have no effect.
- Synchroniser: 2-FF chain per bit (sync1 → sync2). RAW = sync2.
- Debounce, per channel, with counter cnt (width $clog2(DEBOUNCE_CYCLES+1)) and stable level st:
  - If sync2 == st: cnt ← 0.
  - Else if cnt == DEBOUNCE_CYCLES−1: st ← sync2, cnt ← 0, update pulse for one cycle.
  - Else: cnt ← cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles resets cnt and is never seen at DATA.
- Edge events, on the update pulse:
  - Rise when the new st is 1 and RISE_EN[i] is set.
  - Fall when the new st is 0 and FALL_EN[i] is set.
  - Either event sets EDGE_CAPTURE[i].
- EDGE_CAPTURE write: each bit written 1 clears that bit; bits written 0 are unchanged.
  - Set and clear on the same bit in the same cycle: set wins, so no event is lost.
- irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from registers.
- Clearing a RISE_EN/FALL_EN bit stops new captures only; already-captured bits remain set.

## Timing
- Reset values:
  - readdata = 0, irq = 0.
  - sync1, sync2, st, cnt = 0.
  - EDGE_CAPTURE = 0, IRQ_MASK = 0.
  - RISE_EN = FALL_EN = all ones (any-edge, matching the previous generation).
- Reset applies at the clock edge and aborts any debounce in progress; no event is generated by reset itself.
- Read latency: readdata is registered and updated every cycle from the address mux, so data is valid the cycle after address is presented. No wait states.
- Write takes effect at the clock edge where chipselect && !write_n.
- Input to DATA latency: an input held steady from cycle 0 appears at sync2 after 2 cycles and at DATA after 2+DEBOUNCE_CYCLES cycles. EDGE_CAPTURE sets on the same edge as DATA, and irq rises combinationally in that same cycle.
- With in_port high at release of reset, a rise event captures after 2+DEBOUNCE_CYCLES cycles. This is intended; software clears it at init.
- Counter saturation cannot occur, because the counter clears on reaching DEBOUNCE_CYCLES−1.

## Structure
- Package pio_in_pkg holds:
  - Address constants ADDR_DATA, ADDR_RAW, ADDR_MASK, ADDR_CAPT, ADDR_RISE, ADDR_FALL.
  - A counter-width function.
- Sub-module pio_debounce_cell, one instance per channel via a generate loop:
  - Parameter DEBOUNCE_CYCLES.
  - Contains the sync FFs, counter and st.
  - Outputs raw, level and the update pulse.
- The top level contains the register file, capture logic, read mux and irq.

## Test plan
- Reset: drive reset_n=0 for 2 cycles → readdata=0, irq=0; read of RISE_EN returns 0xFF and FALL_EN returns 0xFF (WIDTH=8).
- Debounce (DEBOUNCE_CYCLES=4): in_port[0] 0→1 held → DATA bit 0 = 1 exactly 6 cycles later; a 3-cycle pulse on in_port[1] → DATA and EDGE_CAPTURE stay 0; RAW shows the pulse.
- Edge mode: write RISE_EN=0x01, FALL_EN=0x00, IRQ_MASK=0x01; toggle in_port[0] 0→1→0 with 10-cycle holds → EDGE_CAPTURE=0x01 after the rise only; irq=1.
- W1C: with EDGE_CAPTURE=0x05, write 0x04 → reads 0x01; then write 0x01 on the same cycle a new bit-0 event fires → bit 0 stays 1.
- Masking: EDGE_CAPTURE=0x80, IRQ_MASK=0x7F → irq=0; write IRQ_MASK=0xFF → irq=1 the next cycle.
- Mid-debounce reset: assert reset_n=0 with cnt=2 on a changing input → cnt=0, DATA=0 after reset, no capture.
